// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage: one shift-add or
// restoring-subtract step per cycle, stalling the pipeline until the result is ready.
module ex_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             flush_i,
    input  logic [2:0]       funct3_i,
    input  logic [WIDTH-1:0] rs1_i,
    input  logic [WIDTH-1:0] rs2_i,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     count;
    logic [2:0]           op_q;
    logic                 neg_q, neg_r;
    logic [WIDTH-1:0]     opnd_q;
    logic [2*WIDTH-1:0]   acc_q;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic n);
        logic signed [WIDTH-1:0] s;
        s = $signed(v);
        return n ? $unsigned(-s) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic n);
        logic signed [2*WIDTH-1:0] s;
        s = $signed(v);
        return n ? $unsigned(-s) : v;
    endfunction

    // Operand decode: effective signedness per funct3, magnitudes and special cases
    logic             is_div, a_sgn, b_sgn, a_neg, b_neg;
    logic             div_zero, div_ovf, special;
    logic [WIDTH-1:0] a_mag, b_mag, spec_quot, spec_rem;

    always_comb begin
        is_div    = funct3_i[2];
        a_sgn     = is_div ? ~funct3_i[0] : (funct3_i != 3'b011);
        b_sgn     = is_div ? ~funct3_i[0] : ~funct3_i[1];
        a_neg     = a_sgn & rs1_i[WIDTH-1];
        b_neg     = b_sgn & rs2_i[WIDTH-1];
        a_mag     = neg_w(rs1_i, a_neg);
        b_mag     = neg_w(rs2_i, b_neg);
        div_zero  = is_div & (rs2_i == '0);
        div_ovf   = is_div & ~funct3_i[0] & (rs1_i == {1'b1, {(WIDTH-1){1'b0}}}) & (rs2_i == '1);
        special   = div_zero | div_ovf;
        spec_quot = div_zero ? '1 : {1'b1, {(WIDTH-1){1'b0}}};
        spec_rem  = div_zero ? rs1_i : '0;
    end

    // Iteration step: acc holds {partial, multiplier} or {remainder, dividend/quotient}
    logic [WIDTH:0]     mul_sum, div_trial, div_diff;
    logic [2*WIDTH-1:0] mul_next, div_next;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_trial - {1'b0, opnd_q};
        div_next  = div_diff[WIDTH] ? {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            count  <= '0;
            op_q   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            opnd_q <= '0;
            acc_q  <= '0;
        end else begin
            state <= state_nxt;
            count <= (state == CALC && !flush_i) ? count + CNT_W'(1) : '0;
            if (state == IDLE && start_i && !flush_i) begin
                op_q <= funct3_i;
                if (special) begin
                    // Special results preloaded so the normal result select picks them up
                    neg_q  <= 1'b0;
                    neg_r  <= 1'b0;
                    opnd_q <= '0;
                    acc_q  <= {spec_rem, spec_quot};
                end else begin
                    neg_q  <= a_neg ^ b_neg;
                    neg_r  <= a_neg;
                    opnd_q <= is_div ? b_mag : a_mag;
                    acc_q  <= {{WIDTH{1'b0}}, is_div ? a_mag : b_mag};
                end
            end else if (state == CALC && !flush_i) begin
                acc_q <= op_q[2] ? div_next : mul_next;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i) state_nxt = special ? DONE : CALC;
            CALC:    if (count == CNT_W'(WIDTH-1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush_i) state_nxt = IDLE;
    end

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot, rem, res;

    always_comb begin
        prod  = neg_2w(acc_q, neg_q);
        quot  = neg_w(acc_q[WIDTH-1:0], neg_q);
        rem   = neg_w(acc_q[2*WIDTH-1:WIDTH], neg_r);
        case (op_q)
            3'b000:          res = prod[WIDTH-1:0];
            3'b100, 3'b101:  res = quot;
            3'b110, 3'b111:  res = rem;
            default:         res = prod[2*WIDTH-1:WIDTH];
        endcase
        stall_o  = start_i & (state != DONE);
        done_o   = (state == DONE);
        result_o = (state == DONE) ? res : '0;
    end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: directed vector table, corner-case sequences and
// randomized ops checked against a plain-arithmetic RV32M model.
module tb_ex_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst, start_i, flush_i;
    logic [2:0]  funct3_i;
    logic [31:0] rs1_i, rs2_i;
    logic        stall_o, done_o;
    logic [31:0] result_o;

    int n_checks = 0;
    int n_err    = 0;

    ex_muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .flush_i(flush_i),
        .funct3_i(funct3_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .stall_o(stall_o), .done_o(done_o), .result_o(result_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        string       nm;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, sub;
        logic [63:0]        ua, ub, p;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        sub = $signed(ub);
        p   = '0;
        case (f)
            3'd0: begin p = sa * sb;  return p[31:0];  end
            3'd1: begin p = sa * sb;  return p[63:32]; end
            3'd2: begin p = sa * sub; return p[63:32]; end
            3'd3: begin p = ua * ub;  return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
        return 33;
    endfunction

    // Called just after a rising edge with the unit in IDLE; returns just after
    // the edge that ends the DONE cycle, leaving start_i high.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat, input bit scramble,
                          input string nm);
        int lat;
        bit seen, stall_ok, zero_ok;
        start_i  = 1'b1;
        funct3_i = f3;
        rs1_i    = a;
        rs2_i    = b;
        lat = 0; seen = 0; stall_ok = 1; zero_ok = 1;
        while (!seen && lat <= 80) begin
            @(negedge clk);
            if (done_o) begin
                seen = 1;
                chk({nm, " result"}, result_o, exp);
                chk({nm, " stall_in_done"}, {31'd0, stall_o}, 32'd0);
            end else begin
                if (!stall_o) stall_ok = 0;
                if (result_o != 32'd0) zero_ok = 0;
            end
            @(posedge clk); #1;
            if (!seen) begin
                lat++;
                if (scramble) begin
                    rs1_i    = $urandom;
                    rs2_i    = $urandom;
                    funct3_i = 3'($urandom_range(0, 7));
                end
            end
        end
        chk({nm, " done_seen"}, {31'd0, seen}, 32'd1);
        chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
        chk({nm, " stall_before_done"}, {31'd0, stall_ok}, 32'd1);
        chk({nm, " result_zero_before_done"}, {31'd0, zero_ok}, 32'd1);
    endtask

    task automatic idle_cycle();
        start_i  = 1'b0;
        flush_i  = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic count_done(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done_o) pulses++;
            @(posedge clk); #1;
        end
    endtask

    vec_t tbl[12];

    initial begin
        int pulses;
        logic [2:0]  f3;
        logic [31:0] a, b;

        tbl[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "MUL_7xm3"};
        tbl[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33, "MULH_min"};
        tbl[2]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "MULHSU_ff"};
        tbl[3]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "MULHU_ff"};
        tbl[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33, "DIV_m7_2"};
        tbl[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33, "REM_m7_2"};
        tbl[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        33, "DIVU_100_7"};
        tbl[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         33, "REMU_100_7"};
        tbl[8]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1,  "DIVU_div0"};
        tbl[9]  = '{3'd6, 32'd5,          32'd0,         32'd5,         1,  "REM_div0"};
        tbl[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1,  "DIV_ovf"};
        tbl[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1,  "REM_ovf"};

        rst = 1'b1; start_i = 1'b0; flush_i = 1'b0;
        funct3_i = 3'd0; rs1_i = 32'd0; rs2_i = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset stall_o", {31'd0, stall_o}, 32'd0);
        chk("reset done_o", {31'd0, done_o}, 32'd0);
        chk("reset result_o", result_o, 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            run_op(tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat, 1'b0, tbl[i].nm);
            idle_cycle();
        end

        // Flush at T+10 of a DIV; start drops at T+11
        start_i = 1'b1; funct3_i = 3'd4; rs1_i = 32'd1000; rs2_i = 32'd7;
        repeat (10) begin @(posedge clk); #1; end
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0; start_i = 1'b0;
        @(negedge clk);
        chk("flush stall_o low", {31'd0, stall_o}, 32'd0);
        chk("flush done_o low", {31'd0, done_o}, 32'd0);
        @(posedge clk); #1;
        count_done(40, pulses);
        chk("flush no done pulse", 32'(pulses), 32'd0);
        run_op(3'd0, 32'd3, 32'd4, 32'd12, 33, 1'b0, "MUL_after_flush");
        idle_cycle();

        // Flush together with start in IDLE: nothing starts
        start_i = 1'b1; flush_i = 1'b1; funct3_i = 3'd5; rs1_i = 32'd9; rs2_i = 32'd0;
        @(posedge clk); #1;
        start_i = 1'b0; flush_i = 1'b0;
        count_done(40, pulses);
        chk("flush_with_start no done", 32'(pulses), 32'd0);

        // Flush during DONE still shows the result that cycle
        start_i = 1'b1; funct3_i = 3'd7; rs1_i = 32'd100; rs2_i = 32'd7;
        repeat (33) begin @(posedge clk); #1; end
        flush_i = 1'b1;
        @(negedge clk);
        chk("flush_in_done done_o", {31'd0, done_o}, 32'd1);
        chk("flush_in_done result", result_o, 32'd2);
        @(posedge clk); #1;
        start_i = 1'b0; flush_i = 1'b0;
        @(negedge clk);
        chk("flush_in_done after", {31'd0, done_o}, 32'd0);
        @(posedge clk); #1;

        // Back-to-back with start held: second op sampled right after DONE
        run_op(3'd0, 32'd2, 32'd3, 32'd6, 33, 1'b0, "B2B_MUL");
        run_op(3'd5, 32'd9, 32'd3, 32'd3, 33, 1'b0, "B2B_DIVU");
        idle_cycle();

        // Reset mid-CALC
        start_i = 1'b1; funct3_i = 3'd0; rs1_i = 32'd5; rs2_i = 32'd6;
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1; start_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid stall_o", {31'd0, stall_o}, 32'd0);
        chk("rst_mid done_o", {31'd0, done_o}, 32'd0);
        chk("rst_mid result_o", result_o, 32'd0);
        @(posedge clk); #1;
        count_done(40, pulses);
        chk("rst_mid no done", 32'(pulses), 32'd0);
        run_op(3'd0, 32'd5, 32'd6, 32'd30, 33, 1'b0, "MUL_after_rst");
        idle_cycle();

        // Randomized ops against the reference model
        for (int i = 0; i < 24; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 50); end
                3: b = 32'd1;
                default: ;
            endcase
            run_op(f3, a, b, ref_res(f3, a, b), ref_lat(f3, a, b), i[0], $sformatf("rand%0d_f%0d", i, f3));
            idle_cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
